// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment display blocks.
//   BCD_W         : width of one BCD digit
//   SEG_0..SEG_9  : segment patterns, active-high, bit order gfedcba
//   SEG_BLANK     : all segments off
//   state_t       : scan controller FSM state
//   ptr_t         : digit pointer (tens / units)
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    typedef enum logic {
        PTR_TENS  = 1'b0,
        PTR_UNITS = 1'b1
    } ptr_t;

endpackage

// File: rtl/seg_decode7.sv
// -----------------------------------------------------------------------------
// seg_decode7
// Purely combinational BCD to 7-segment decoder (active-high, gfedcba).
// Codes 10-15 produce a blank pattern.
// Ports:
//   bcd_i : BCD digit in
//   seg_o : segment pattern out
// -----------------------------------------------------------------------------
module seg_decode7
    import seg_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [6:0]       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Two-digit multiplexed 7-segment scan controller. Each digit slot lasts
// SCAN_DIV cycles; the first BLANK_CYC cycles of a slot keep all anodes off
// to avoid ghosting. The digit shown in a slot is latched on the edge that
// starts the slot, so input changes mid-slot are ignored.
// Optional feature: define SEG_LZB_EN for leading-zero blanking of the tens
// digit (slot timing and frame pulse are unaffected).
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   en    : scan enable (0 returns to IDLE on the sampled edge)
//   dig1  : tens digit, BCD
//   dig2  : units digit, BCD
//   seg   : segment pattern, active-high, gfedcba
//   an    : one-hot digit select, an[1]=tens, an[0]=units
//   frame : one-cycle pulse on the last cycle of each tens+units scan
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [BCD_W-1:0] dig1,
    input  logic [BCD_W-1:0] dig2,
    output logic [6:0]       seg,
    output logic [1:0]       an,
    output logic             frame
);

    localparam int             CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    ptr_t               ptr_q,   ptr_d;
    logic [BCD_W-1:0]   dig_q,   dig_d;
    logic [6:0]         seg_dec;

    seg_decode7 u_dec (
        .bcd_i (dig_q),
        .seg_o (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= PTR_TENS;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            dig_q   <= dig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        dig_d   = dig_q;
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ptr_d   = PTR_TENS;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    ptr_d   = PTR_TENS;
                    dig_d   = dig1;
                end
                ST_BLANK: begin
                    // Blanking never reaches the slot end since SCAN_DIV > BLANK_CYC.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_MAX) begin
                        // Slot boundary: latch the digit belonging to the new pointer.
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        ptr_d   = (ptr_q == PTR_TENS) ? PTR_UNITS : PTR_TENS;
                        dig_d   = (ptr_q == PTR_TENS) ? dig2 : dig1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ptr_d   = PTR_TENS;
                end
            endcase
        end
    end

    // Outputs depend only on registered state.
    always_comb begin
        seg   = SEG_BLANK;
        an    = 2'b00;
        frame = 1'b0;
        if (state_q == ST_SHOW) begin
            an  = (ptr_q == PTR_TENS) ? 2'b10 : 2'b01;
            seg = seg_dec;
`ifdef SEG_LZB_EN
            if ((ptr_q == PTR_TENS) && (dig_q == '0)) begin
                an  = 2'b00;
                seg = SEG_BLANK;
            end
`endif
            frame = (cnt_q == CNT_MAX) && (ptr_q == PTR_UNITS);
        end
    end

endmodule
